// File: rtl/dff_mux_nx1.sv
// dff_mux_nx1: registered N:1 channel mux with manual/round-robin select and valid/ready handshake.
// Define DFF_MUX_NX1_PARITY_EN to add the registered parity output f_par.
module dff_mux_nx1 #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] x,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          f,
  output logic [SEL_W-1:0]          f_sel,
  output logic                      sel_err,
`ifdef DFF_MUX_NX1_PARITY_EN
  output logic                      f_par,
`endif
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ch;
  logic [SEL_W-1:0] rr_nxt;
  logic [WIDTH-1:0] d;
  logic             hit;
  logic             cap;
  assign in_ready = !out_valid || out_ready;
  assign cap      = in_valid && in_ready;
  assign ch       = auto ? rr_ptr : sel;
  assign rr_nxt   = (rr_ptr == SEL_W'(CHANNELS - 1)) ? '0 : rr_ptr + 1'b1;
  // an unmatched index is out of range, so d stays zero
  always_comb begin
    d   = '0;
    hit = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch == SEL_W'(k)) begin
        d   = x[k*WIDTH +: WIDTH];
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f         <= '0;
      f_sel     <= '0;
      sel_err   <= 1'b0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (cap) begin
      f         <= d;
      f_sel     <= ch;
      sel_err   <= !hit;
      out_valid <= 1'b1;
      if (auto) rr_ptr <= rr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef DFF_MUX_NX1_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_par <= 1'b0;
    else if (cap) f_par <= ^d;
  end
`endif
endmodule
